// File: rtl/trivium_pkg.sv
// Shared constants and FSM encoding for the bit-serial Trivium cipher.
package trivium_pkg;

  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int STATE_W       = 288;
  localparam int WARMUP_CYCLES = 1152;
  localparam int LOAD_CYCLES   = KEY_W + IV_W;
  localparam int LOAD_CNT_W    = 8;
  localparam int WARM_CNT_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } trivium_state_e;

endpackage

// File: rtl/trivium_if.sv
// Serial data/control bundle between a data source (master) and the cipher (slave).
// busy_o exists only when TRIVIUM_BUSY_EN is defined.
interface trivium_if;
  logic dat_i;
  logic init_i;
  logic end_i;
  logic dat_o;
`ifdef TRIVIUM_BUSY_EN
  logic busy_o;

  modport master (output dat_i, output init_i, output end_i, input dat_o, input busy_o);
  modport slave  (input dat_i, input init_i, input end_i, output dat_o, output busy_o);
`else
  modport master (output dat_i, output init_i, output end_i, input dat_o);
  modport slave  (input dat_i, input init_i, input end_i, output dat_o);
`endif
endinterface

// File: rtl/trivium_round.sv
// One combinational Trivium round: keystream bit z from the current state plus the shifted state.
// Vector bit k-1 holds state bit s_k.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] cur_state_s,
  output logic [STATE_W-1:0] nxt_state_s,
  output logic               z_s
);

  logic t1_s;
  logic t2_s;
  logic t3_s;
  logic t1_fb_s;
  logic t2_fb_s;
  logic t3_fb_s;

  // Tap extraction, keystream bit and nonlinear feedback for the three registers
  always_comb begin
    t1_s        = cur_state_s[65]  ^ cur_state_s[92];
    t2_s        = cur_state_s[161] ^ cur_state_s[176];
    t3_s        = cur_state_s[242] ^ cur_state_s[287];
    z_s         = t1_s ^ t2_s ^ t3_s;
    t1_fb_s     = t1_s ^ (cur_state_s[90]  & cur_state_s[91])  ^ cur_state_s[170];
    t2_fb_s     = t2_s ^ (cur_state_s[174] & cur_state_s[175]) ^ cur_state_s[263];
    t3_fb_s     = t3_s ^ (cur_state_s[285] & cur_state_s[286]) ^ cur_state_s[68];
    nxt_state_s = {cur_state_s[286:177], t2_fb_s,
                   cur_state_s[175:93],  t1_fb_s,
                   cur_state_s[91:0],    t3_fb_s};
  end

endmodule

// File: rtl/trivium_top.sv
// Bit-serial Trivium: serial key/IV load, 1152-round warm-up, then dat_o = dat_i ^ keystream.
// Optional TRIVIUM_BUSY_EN adds a registered busy_o flag (high in LOAD and WARMUP).
module trivium_top
  import trivium_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  trivium_if.slave  bus
);

  // Constant part of the freshly loaded state: s286..s288 = 1, everything else filled by the load
  localparam logic [STATE_W-1:0] LOAD_BASE = {3'b111, 285'd0};

  trivium_state_e          fsm_r;
  logic [STATE_W-1:0]      state_r;
  logic [LOAD_CNT_W-1:0]   load_cnt_r;
  logic [WARM_CNT_W-1:0]   warm_cnt_r;
  logic                    dat_o_r;
  logic [STATE_W-1:0]      nxt_state_s;
  logic                    z_s;
  logic [LOAD_CNT_W-1:0]   load_idx_s;
  logic [8:0]              load_pos_s;
`ifdef TRIVIUM_BUSY_EN
  logic                    busy_r;
`endif

  trivium_round u_round (
    .cur_state_s (state_r),
    .nxt_state_s (nxt_state_s),
    .z_s         (z_s)
  );

  // Map the running bit index onto its state position: key to s1..s80, IV to s94..s173
  always_comb begin
    load_idx_s = load_cnt_r + 8'd1;
    if (load_idx_s < 8'(KEY_W)) begin
      load_pos_s = {1'b0, load_idx_s};
    end else begin
      load_pos_s = {1'b0, load_idx_s} + 9'd13;
    end
  end

  // Control FSM together with cipher state, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_r      <= ST_IDLE;
      state_r    <= {STATE_W{1'b0}};
      load_cnt_r <= {LOAD_CNT_W{1'b0}};
      warm_cnt_r <= {WARM_CNT_W{1'b0}};
      dat_o_r    <= 1'b0;
`ifdef TRIVIUM_BUSY_EN
      busy_r     <= 1'b0;
`endif
    end else if (bus.end_i) begin
      fsm_r      <= ST_IDLE;
      state_r    <= {STATE_W{1'b0}};
      load_cnt_r <= {LOAD_CNT_W{1'b0}};
      warm_cnt_r <= {WARM_CNT_W{1'b0}};
      dat_o_r    <= 1'b0;
`ifdef TRIVIUM_BUSY_EN
      busy_r     <= 1'b0;
`endif
    end else if (bus.init_i && (fsm_r != ST_LOAD)) begin
      // (Re)start: the current dat_i is key bit K1
      fsm_r      <= ST_LOAD;
      state_r    <= LOAD_BASE | {287'd0, bus.dat_i};
      load_cnt_r <= {LOAD_CNT_W{1'b0}};
      warm_cnt_r <= {WARM_CNT_W{1'b0}};
      dat_o_r    <= 1'b0;
`ifdef TRIVIUM_BUSY_EN
      busy_r     <= 1'b1;
`endif
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          dat_o_r <= 1'b0;
        end
        ST_LOAD: begin
          dat_o_r             <= 1'b0;
          state_r[load_pos_s] <= bus.dat_i;
          load_cnt_r          <= load_idx_s;
          if (load_idx_s == 8'(LOAD_CYCLES - 1)) begin
            fsm_r      <= ST_WARMUP;
            warm_cnt_r <= {WARM_CNT_W{1'b0}};
          end
        end
        ST_WARMUP: begin
          dat_o_r <= 1'b0;
          state_r <= nxt_state_s;
          if (warm_cnt_r == 11'(WARMUP_CYCLES - 1)) begin
            fsm_r  <= ST_RUN;
`ifdef TRIVIUM_BUSY_EN
            busy_r <= 1'b0;
`endif
          end else begin
            warm_cnt_r <= warm_cnt_r + 11'd1;
          end
        end
        ST_RUN: begin
          state_r <= nxt_state_s;
          dat_o_r <= bus.dat_i ^ z_s;
        end
        default: begin
          fsm_r   <= ST_IDLE;
          state_r <= {STATE_W{1'b0}};
          dat_o_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dat_o = dat_o_r;
`ifdef TRIVIUM_BUSY_EN
  assign bus.busy_o = busy_r;
`endif

endmodule

// File: tb/tb_trivium_top.sv
// Randomized self-checking bench for trivium_top against a 1-based array model of the cipher.
module tb_trivium_top;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   ms [1:288];

  trivium_if bus ();

  trivium_top dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  // Reference round written directly from the cipher equations on s[1..288]
  task automatic model_round(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
    ms[178] = t2;
  endtask

  task automatic model_load(input logic [79:0] key, input logic [79:0] iv);
    bit z;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = key[i-1];
      ms[93 + i] = iv[i-1];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int r = 0; r < 1152; r++) model_round(z);
  endtask

  // Drive one full load plus warm-up; optionally pulse init_i inside LOAD, which must be ignored
  task automatic load_session(input logic [79:0] key, input logic [79:0] iv, input bit glitch);
    int nz;
    model_load(key, iv);
    nz = 0;
    bus.init_i = 1'b1;
    bus.dat_i  = key[0];
    step();
    bus.init_i = 1'b0;
`ifdef TRIVIUM_BUSY_EN
    chk("busy_load", {31'd0, bus.busy_o}, 32'd1);
`endif
    for (int i = 1; i < 160; i++) begin
      bus.dat_i  = (i < 80) ? key[i] : iv[i-80];
      bus.init_i = glitch && (i == 50);
      step();
      nz += int'(bus.dat_o);
    end
    bus.init_i = 1'b0;
    for (int i = 0; i < 1152; i++) begin
      bus.dat_i = 1'($urandom());
      step();
      nz += int'(bus.dat_o);
`ifdef TRIVIUM_BUSY_EN
      if (i == 1150) chk("busy_warm_end", {31'd0, bus.busy_o}, 32'd1);
`endif
    end
    chk("load_warm_quiet", nz, 32'd0);
`ifdef TRIVIUM_BUSY_EN
    chk("busy_run", {31'd0, bus.busy_o}, 32'd0);
`endif
  endtask

  // Push 32 bits LSB first through RUN and compare with plaintext ^ model keystream
  task automatic run_word(input logic [31:0] pt, output logic [31:0] got, input string tag);
    logic [31:0] expv;
    bit z;
    for (int i = 0; i < 32; i++) begin
      bus.dat_i = pt[i];
      model_round(z);
      expv[i] = pt[i] ^ z;
      step();
      got[i] = bus.dat_o;
    end
    chk(tag, got, expv);
  endtask

  initial begin
    logic [31:0] ct;
    logic [31:0] got;
    logic [79:0] k3;
    logic [79:0] iv3;
    int nz;

    rst_i      = 1'b1;
    bus.init_i = 1'b1;
    bus.end_i  = 1'b0;
    bus.dat_i  = 1'b1;
    repeat (3) step();
    chk("rst_dat_o", {31'd0, bus.dat_o}, 32'd0);
`ifdef TRIVIUM_BUSY_EN
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
`endif
    rst_i      = 1'b0;
    bus.init_i = 1'b0;
    repeat (3) step();
    chk("idle_quiet", {31'd0, bus.dat_o}, 32'd0);

    load_session(80'd0, 80'd0, 1'b0);
    run_word(32'd0, got, "zero_ks");

    k3  = 80'h0123456789ABCDEF0123;
    iv3 = 80'hFEDCBA98765432100123;
    load_session(k3, iv3, 1'b1);
    run_word(32'hDEADBEEF, ct, "enc_known");
    load_session(k3, iv3, 1'b0);
    run_word(ct, got, "dec_known");
    chk("decrypt", got, 32'hDEADBEEF);

    for (int n = 0; n < 3; n++) begin
      load_session(rand80(), rand80(), 1'(n));
      run_word($urandom(), got, "rekey_ks");
      run_word($urandom(), got, "rekey_ks2");
    end

    bus.end_i  = 1'b1;
    bus.init_i = 1'b1;
    bus.dat_i  = 1'b1;
    step();
    chk("end_init", {31'd0, bus.dat_o}, 32'd0);
    bus.end_i  = 1'b0;
    bus.init_i = 1'b0;
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      bus.dat_i = 1'($urandom());
      step();
      nz += int'(bus.dat_o);
    end
    chk("end_idle", nz, 32'd0);
    load_session(rand80(), rand80(), 1'b0);
    run_word($urandom(), got, "after_end");

    #3;
    rst_i      = 1'b1;
    bus.init_i = 1'b1;
    bus.dat_i  = 1'b1;
    #1;
    chk("rst_async", {31'd0, bus.dat_o}, 32'd0);
`ifdef TRIVIUM_BUSY_EN
    chk("rst_async_busy", {31'd0, bus.busy_o}, 32'd0);
`endif
    repeat (2) step();
    rst_i      = 1'b0;
    bus.init_i = 1'b0;
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      bus.dat_i = 1'($urandom());
      step();
      nz += int'(bus.dat_o);
    end
    chk("post_rst_idle", nz, 32'd0);
    load_session(rand80(), rand80(), 1'b0);
    run_word($urandom(), got, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
